xnor_seq_reducer: RTL and testbench
===================================

Name: xnor_seq_reducer

Overview:
- Multi-cycle controller that time-shares one 2-input xnor_gate instance to reduce an N-bit word, one bit per clock.
- Produces two results: the cascaded 2-input chain result, and the true N-input XNOR (~^data) as a reference.
- Flags any mismatch between them, which is the cascade-vs-native equivalence check of the basic-gates library in sequenced hardware form.
- Sits between a valid/ready producer and consumer.

Parameters:
- N, 4, number of input bits; legal range 2..64.
- CW, $clog2(N), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  N  word to reduce; bit 0 is consumed first.
- out_valid  output  1  results are available.
- out_ready  input  1  consumer takes the results.
- chain_out  output  1  result of the N-1 cascaded 2-input XNOR stages.
- ref_out  output  1  true N-input XNOR of the captured word (~^data).
- mismatch  output  1  chain_out != ref_out.
- busy  output  1  state is not IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset state: IDLE.
- Reset values:
  - in_ready=1.
  - out_valid=0, chain_out=0, ref_out=0, mismatch=0, busy=0.
  - Internal data_q=0, acc=0, cnt=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid&&in_ready.
  - On accept: data_q<=in_data, acc<=in_data[0], cnt<=1, go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored and data_q is frozen.
  - Each cycle: acc<=xnor(acc, data_q[cnt]), computed by the single shared xnor_gate instance.
  - If cnt==N-1, go to DONE; otherwise cnt<=cnt+1.
  - RUN lasts exactly N-1 cycles.
- DONE:
  - out_valid=1, chain_out=acc, ref_out=~^data_q, mismatch=chain_out^ref_out.
  - Outputs hold stable while out_ready=0 (back-pressure, no timeout).
  - When out_valid&&out_ready, go to IDLE. No accept happens in the same cycle; in_ready rises the next cycle.
- Latency: out_valid rises N-1 cycles after the accept edge (N=2 gives 1 cycle).
- Throughput: one word per N+1 cycles when out_ready is held high.
- Outputs outside DONE:
  - chain_out, ref_out and mismatch are driven 0.
  - out_valid=0.
- Arithmetic identity (verification oracle):
  - chain_out = (^data) ^ ((N-1)&1).
  - mismatch = 1 exactly when N is odd, for every data value.
- Reset in RUN or DONE:
  - Aborts immediately on the next edge: state IDLE, all outputs at reset values.
  - The in-flight word is discarded and no out_valid is produced for it.
- in_valid asserted during reset: not accepted; acceptance starts on the first edge after rst falls.
- in_data changing in RUN or DONE has no effect.

Decomposition:
- Shared package xnor_pkg holds:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function ref_xnor(data) returning ~^data, used by both RTL and the bench.
- One sub-module: xnor_gate, the existing 2-input library gate, instantiated exactly once as the shared datapath.
- FSM, counter and registers stay in xnor_seq_reducer.

Test Plan:
- N=3, in_data=3'b000, out_ready=1:
  - Stages give xnor(0,0)=1, then xnor(1,0)=0.
  - out_valid rises 2 cycles after accept with chain_out=0, ref_out=1, mismatch=1.
- N=3, in_data=3'b101: chain_out=0, ref_out=1, mismatch=1; busy is high for exactly 3 cycles.
- N=4, in_data=4'b1011:
  - acc goes 1 -> 1 -> 0 -> 0.
  - chain_out=0, ref_out=0, mismatch=0; out_valid 3 cycles after accept.
- Back-pressure: N=4, hold out_ready=0 for 5 cycles in DONE:
  - out_valid and results stay stable.
  - in_valid pulses in that window are not accepted (in_ready=0).
  - Raising out_ready returns to IDLE; in_ready=1 on the next cycle.
- Reset mid-operation: N=8, assert rst during the 3rd RUN cycle for 1 cycle:
  - Next edge gives IDLE, busy=0, out_valid=0.
  - A new word 8'hA5 afterwards completes normally: chain_out=1, ref_out=1, mismatch=0.
- Randomised sweep: N=2,5,8 with random in_data and random out_ready:
  - chain_out matches (^data)^((N-1)&1).
  - mismatch==N[0] every transaction.
  - Latency is always N-1 cycles.

Source files
------------

// File: rtl/xnor_pkg.sv
// Shared types and the reference reduction used by the sequenced XNOR reducer
// and anything that needs to check its results.
package xnor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero-extending a narrower word does not change its XOR parity, so one
    // 64-bit function serves every legal N.
    function automatic logic ref_xnor(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/xnor_gate.sv
// Two-input XNOR from the basic-gates library; used as the shared datapath
// stage of the sequenced reducer.
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_seq_reducer.sv
// Reduces an N-bit word through one shared 2-input XNOR, one bit per clock,
// and reports the cascade result next to the native N-input XNOR.
module xnor_seq_reducer
    import xnor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         chain_out,
    output logic         ref_out,
    output logic         mismatch,
    output logic         busy
);

    localparam int CW = $clog2(N);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   data_q;
    logic           acc;
    logic [CW-1:0]  cnt;
    logic           gate_y;
    logic           last_bit;
    logic           accept;
    logic           ref_val;

    assign last_bit = (cnt == CW'(N - 1));
    assign accept   = in_valid && in_ready;
    assign ref_val  = ref_xnor(64'(data_q));

    xnor_gate u_gate (
        .a (acc),
        .b (data_q[cnt]),
        .y (gate_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit 0 seeds the accumulator, so RUN only needs N-1 gate evaluations.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            acc    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= in_data;
                        acc    <= in_data[0];
                        cnt    <= CW'(1);
                    end
                end
                RUN: begin
                    acc <= gate_y;
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        chain_out  = 1'b0;
        ref_out    = 1'b0;
        mismatch   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                chain_out = acc;
                ref_out   = ref_val;
                mismatch  = acc ^ ref_val;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xnor_seq_reducer.sv
// Directed bench for xnor_seq_reducer: five instances (N = 2, 3, 4, 5, 8)
// share clock, reset, data and out_ready; only one instance is driven at a time.
module tb_xnor_seq_reducer;

    logic       clk;
    logic       rst;
    logic [4:0] iv;
    logic [4:0] ir;
    logic [4:0] ov;
    logic [4:0] co;
    logic [4:0] ro;
    logic [4:0] mm;
    logic [4:0] bz;
    logic [7:0] din;
    logic       ordy;

    int checks = 0;
    int errors = 0;
    int ns[5] = '{2, 3, 4, 5, 8};

    xnor_seq_reducer #(.N(2)) dut2 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[1:0]), .out_valid(ov[0]), .out_ready(ordy), .chain_out(co[0]),
        .ref_out(ro[0]), .mismatch(mm[0]), .busy(bz[0]));
    xnor_seq_reducer #(.N(3)) dut3 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[2:0]), .out_valid(ov[1]), .out_ready(ordy), .chain_out(co[1]),
        .ref_out(ro[1]), .mismatch(mm[1]), .busy(bz[1]));
    xnor_seq_reducer #(.N(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[3:0]), .out_valid(ov[2]), .out_ready(ordy), .chain_out(co[2]),
        .ref_out(ro[2]), .mismatch(mm[2]), .busy(bz[2]));
    xnor_seq_reducer #(.N(5)) dut5 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(din[4:0]), .out_valid(ov[3]), .out_ready(ordy), .chain_out(co[3]),
        .ref_out(ro[3]), .mismatch(mm[3]), .busy(bz[3]));
    xnor_seq_reducer #(.N(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
        .in_data(din[7:0]), .out_valid(ov[4]), .out_ready(ordy), .chain_out(co[4]),
        .ref_out(ro[4]), .mismatch(mm[4]), .busy(bz[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d);
        din   = d;
        iv[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (ov[k] !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv  = 5'b11111;
        din = 8'hFF;
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({ir[k], ov[k], co[k], ro[k], mm[k], bz[k]} !== 6'b100000) begin
                errors++;
                $display("[TB] FAIL reset_values n=%0d got %b want 100000", ns[k],
                         {ir[k], ov[k], co[k], ro[k], mm[k], bz[k]});
            end
        end
        iv  = 5'b00010;
        din = 8'h00;
        tick();
        checks++;
        if (bz[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_in_reset busy got %b want 0", bz[1]);
        end
        rst = 1'b0;
        tick();
        iv = 5'b00000;
        checks++;
        if ({bz[1], ir[1]} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL accept_after_reset busy/in_ready got %b want 10", {bz[1], ir[1]});
        end
        repeat (4) tick();
        checks++;
        if (bz[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_after_reset busy got %b want 0", bz[1]);
        end
    endtask

    task automatic test_n3_zero();
        int lat;
        ordy = 1'b1;
        send(1, 8'b000);
        wait_done(1, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL n3_zero latency got %0d want 2", lat);
        end
        checks++;
        if ({co[1], ro[1], mm[1]} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL n3_zero results got %b want 011", {co[1], ro[1], mm[1]});
        end
        tick();
        checks++;
        if ({ov[1], bz[1], ir[1]} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL n3_zero return got %b want 001", {ov[1], bz[1], ir[1]});
        end
    endtask

    task automatic test_n3_busy();
        int  busy_cycles;
        logic [2:0] res;
        ordy = 1'b1;
        res  = 3'bxxx;
        send(1, 8'b101);
        busy_cycles = 0;
        while (bz[1] === 1'b1 && busy_cycles < 20) begin
            if (ov[1] === 1'b1) res = {co[1], ro[1], mm[1]};
            busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles !== 3) begin
            errors++;
            $display("[TB] FAIL n3_busy_cycles got %0d want 3", busy_cycles);
        end
        checks++;
        if (res !== 3'b011) begin
            errors++;
            $display("[TB] FAIL n3_101 results got %b want 011", res);
        end
    endtask

    task automatic test_n4();
        int lat;
        ordy = 1'b1;
        send(2, 8'b1011);
        wait_done(2, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL n4_latency got %0d want 3", lat);
        end
        checks++;
        if ({co[2], ro[2], mm[2]} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL n4_1011 results got %b want 000", {co[2], ro[2], mm[2]});
        end
        tick();
    endtask

    task automatic test_back_pressure();
        int lat;
        ordy = 1'b0;
        send(2, 8'b0110);
        wait_done(2, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL bp_latency got %0d want 3", lat);
        end
        for (int c = 0; c < 5; c++) begin
            iv[2] = (c % 2 == 0);
            din   = 8'($urandom);
            tick();
            checks++;
            if ({ov[2], co[2], ro[2], mm[2], ir[2]} !== 5'b11100) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d got %b want 11100", c,
                         {ov[2], co[2], ro[2], mm[2], ir[2]});
            end
        end
        iv[2] = 1'b0;
        ordy  = 1'b1;
        tick();
        checks++;
        if ({ov[2], bz[2], ir[2]} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL bp_release got %b want 001", {ov[2], bz[2], ir[2]});
        end
        tick();
        checks++;
        if (bz[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_stray_accept busy got %b want 0", bz[2]);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic seen_ov;
        ordy = 1'b1;
        send(4, 8'hFF);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bz[4], ov[4], ir[4], co[4]} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL reset_mid state got %b want 0010", {bz[4], ov[4], ir[4], co[4]});
        end
        seen_ov = 1'b0;
        repeat (12) begin
            tick();
            if (ov[4] !== 1'b0) seen_ov = 1'b1;
        end
        checks++;
        if (seen_ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid stray out_valid got %b want 0", seen_ov);
        end
        send(4, 8'hA5);
        wait_done(4, lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("[TB] FAIL reset_mid latency got %0d want 7", lat);
        end
        checks++;
        if ({co[4], ro[4], mm[4]} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_mid A5 results got %b want 110", {co[4], ro[4], mm[4]});
        end
        tick();
    endtask

    task automatic test_random_sweep();
        int         ks[3] = '{0, 3, 4};
        int         k;
        int         n;
        int         lat;
        int         guard;
        logic [7:0] d;
        logic       exp_c;
        logic       exp_r;
        logic       exp_m;
        logic       r;
        logic       done;
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 6; t++) begin
                k     = ks[i];
                n     = ns[k];
                d     = 8'($urandom) & 8'((1 << n) - 1);
                exp_c = (^d) ^ 1'((n - 1) & 1);
                exp_r = ~(^d);
                exp_m = 1'(n & 1);
                ordy  = 1'($urandom_range(0, 1));
                send(k, d);
                lat = 0;
                while (ov[k] !== 1'b1 && lat < 100) begin
                    ordy = 1'($urandom_range(0, 1));
                    tick();
                    lat++;
                end
                checks++;
                if (lat !== n - 1) begin
                    errors++;
                    $display("[TB] FAIL sweep_latency n=%0d d=%h got %0d want %0d", n, d, lat, n - 1);
                end
                checks++;
                if ({co[k], ro[k], mm[k]} !== {exp_c, exp_r, exp_m}) begin
                    errors++;
                    $display("[TB] FAIL sweep_results n=%0d d=%h got %b want %b", n, d,
                             {co[k], ro[k], mm[k]}, {exp_c, exp_r, exp_m});
                end
                done  = 1'b0;
                guard = 0;
                while (!done && guard < 50) begin
                    r    = 1'($urandom_range(0, 1));
                    ordy = r;
                    tick();
                    guard++;
                    checks++;
                    if (r) begin
                        done = 1'b1;
                        if ({ov[k], bz[k]} !== 2'b00) begin
                            errors++;
                            $display("[TB] FAIL sweep_release n=%0d got %b want 00", n, {ov[k], bz[k]});
                        end
                    end else if ({ov[k], co[k], ro[k], mm[k]} !== {1'b1, exp_c, exp_r, exp_m}) begin
                        errors++;
                        $display("[TB] FAIL sweep_hold n=%0d got %b want %b", n,
                                 {ov[k], co[k], ro[k], mm[k]}, {1'b1, exp_c, exp_r, exp_m});
                    end
                end
                if (!done) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sweep_drain_timeout n=%0d got busy want idle", n);
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        iv   = 5'b00000;
        din  = 8'h00;
        ordy = 1'b1;
        test_reset();
        test_n3_zero();
        test_n3_busy();
        test_n4();
        test_back_pressure();
        test_reset_mid();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
